// File: rtl/wb_queue.sv
// Four-lane compacting writeback queue feeding register-file write port 0.
// Optional macro WB_QUEUE_ZERO_DROP_EN drops lanes that target register 0 at capture.
module wb_queue #(
  parameter int DEPTH = 8  // power of two, >= 4
) (
  input  logic                       clk,
  input  logic                       rstN,
  input  logic                       inValid0,
  input  logic                       inValid1,
  input  logic                       inValid2,
  input  logic                       inValid3,
  input  logic [4:0]                 inAddr0,
  input  logic [4:0]                 inAddr1,
  input  logic [4:0]                 inAddr2,
  input  logic [4:0]                 inAddr3,
  input  logic [31:0]                inData0,
  input  logic [31:0]                inData1,
  input  logic [31:0]                inData2,
  input  logic [31:0]                inData3,
  output logic                       inReady,
  input  logic                       flush,
  input  logic                       outStall,
  output logic                       outValid,
  output logic [4:0]                 outAddr,
  output logic [31:0]                outData,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]    mem_addr [DEPTH];
  logic [31:0]   mem_data [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] free;

  logic [3:0]    lane_v;
  logic [4:0]    lane_a [4];
  logic [31:0]   lane_d [4];
  logic [2:0]    off    [4];
  logic [2:0]    n_cap;
  logic [2:0]    n_take;
  logic          pop;

  always_comb begin
    lane_a[0] = inAddr0;
    lane_a[1] = inAddr1;
    lane_a[2] = inAddr2;
    lane_a[3] = inAddr3;
    lane_d[0] = inData0;
    lane_d[1] = inData1;
    lane_d[2] = inData2;
    lane_d[3] = inData3;
`ifdef WB_QUEUE_ZERO_DROP_EN
    lane_v[0] = inValid0 && (inAddr0 != 5'd0);
    lane_v[1] = inValid1 && (inAddr1 != 5'd0);
    lane_v[2] = inValid2 && (inAddr2 != 5'd0);
    lane_v[3] = inValid3 && (inAddr3 != 5'd0);
`else
    lane_v[0] = inValid0;
    lane_v[1] = inValid1;
    lane_v[2] = inValid2;
    lane_v[3] = inValid3;
`endif
  end

  // Slot offset of each lane relative to wr_ptr: running count of earlier valid lanes.
  always_comb begin
    off[0] = 3'd0;
    off[1] = off[0] + {2'b00, lane_v[0]};
    off[2] = off[1] + {2'b00, lane_v[1]};
    off[3] = off[2] + {2'b00, lane_v[2]};
    n_cap  = off[3] + {2'b00, lane_v[3]};
  end

  // Ready comes only from registered occupancy, so no inValid -> inReady path.
  assign free     = CW'(DEPTH) - count;
  assign inReady  = (free >= CW'(4));
  assign n_take   = inReady ? n_cap : 3'd0;

  assign outValid = (count != '0);
  assign pop      = outValid && !outStall;
  assign outAddr  = outValid ? mem_addr[rd_ptr] : 5'd0;
  assign outData  = outValid ? mem_data[rd_ptr] : 32'd0;

  always_ff @(posedge clk) begin
    for (int n = 0; n < 4; n++) begin
      if (inReady && lane_v[n]) begin
        mem_addr[wr_ptr + AW'(off[n])] <= lane_a[n];
        mem_data[wr_ptr + AW'(off[n])] <= lane_d[n];
      end
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(n_take);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + CW'(n_take) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_wb_queue.sv
// Directed bench for wb_queue (DEPTH=8); honours WB_QUEUE_ZERO_DROP_EN if defined.
module tb_wb_queue;

  logic        clk = 1'b0;
  logic        rstN;
  logic        inValid0, inValid1, inValid2, inValid3;
  logic [4:0]  inAddr0, inAddr1, inAddr2, inAddr3;
  logic [31:0] inData0, inData1, inData2, inData3;
  logic        inReady, flush, outStall, outValid;
  logic [4:0]  outAddr;
  logic [31:0] outData;
  logic [3:0]  count;

  int n_cmp = 0;
  int n_err = 0;

  wb_queue #(.DEPTH(8)) dut (
    .clk(clk), .rstN(rstN),
    .inValid0(inValid0), .inValid1(inValid1), .inValid2(inValid2), .inValid3(inValid3),
    .inAddr0(inAddr0), .inAddr1(inAddr1), .inAddr2(inAddr2), .inAddr3(inAddr3),
    .inData0(inData0), .inData1(inData1), .inData2(inData2), .inData3(inData3),
    .inReady(inReady), .flush(flush), .outStall(outStall),
    .outValid(outValid), .outAddr(outAddr), .outData(outData), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_lanes();
    {inValid0, inValid1, inValid2, inValid3} = 4'b0000;
    {inAddr0, inAddr1, inAddr2, inAddr3} = '0;
    {inData0, inData1, inData2, inData3} = '0;
  endtask

  task automatic burst4(input logic [4:0] a0, input logic [31:0] d0);
    {inValid0, inValid1, inValid2, inValid3} = 4'b1111;
    inAddr0 = a0;        inData0 = d0;
    inAddr1 = a0 + 5'd1; inData1 = d0 + 32'd1;
    inAddr2 = a0 + 5'd2; inData2 = d0 + 32'd2;
    inAddr3 = a0 + 5'd3; inData3 = d0 + 32'd3;
  endtask

  task automatic check_head(input string tag, input logic [4:0] a, input logic [31:0] d);
    check({tag, "_valid"}, 32'(outValid), 32'd1);
    check({tag, "_addr"}, 32'(outAddr), 32'(a));
    check({tag, "_data"}, outData, d);
  endtask

  task automatic check_empty(input string tag);
    check({tag, "_valid"}, 32'(outValid), 32'd0);
    check({tag, "_count"}, 32'(count), 32'd0);
    check({tag, "_addr"}, 32'(outAddr), 32'd0);
    check({tag, "_data"}, outData, 32'd0);
  endtask

  initial begin
    rstN = 1'b0; flush = 1'b0; outStall = 1'b0;
    idle_lanes();
    #12;
    check_empty("reset");
    check("reset_ready", 32'(inReady), 32'd1);
    #3 rstN = 1'b1;
    tick();

    // four lanes in one cycle, drained on consecutive cycles
    inValid0 = 1; inAddr0 = 5'd1; inData0 = 32'hAAAA_0001;
    inValid1 = 1; inAddr1 = 5'd2; inData1 = 32'hBBBB_0002;
    inValid2 = 1; inAddr2 = 5'd3; inData2 = 32'hCCCC_0003;
    inValid3 = 1; inAddr3 = 5'd4; inData3 = 32'hDDDD_0004;
    check("t1_pre_empty", 32'(outValid), 32'd0);
    tick(); idle_lanes();
    check("t1_count4", 32'(count), 32'd4);
    check_head("t1_h0", 5'd1, 32'hAAAA_0001); tick();
    check_head("t1_h1", 5'd2, 32'hBBBB_0002); tick();
    check_head("t1_h2", 5'd3, 32'hCCCC_0003); tick();
    check_head("t1_h3", 5'd4, 32'hDDDD_0004); tick();
    check_empty("t1_done");

    // compaction: lanes 1 and 3 only
    inValid1 = 1; inAddr1 = 5'd7; inData1 = 32'h0000_7777;
    inValid3 = 1; inAddr3 = 5'd9; inData3 = 32'h0000_9999;
    tick(); idle_lanes();
    check("t2_count2", 32'(count), 32'd2);
    check_head("t2_h0", 5'd7, 32'h0000_7777); tick();
    check_head("t2_h1", 5'd9, 32'h0000_9999); tick();
    check_empty("t2_done");

    // fill to DEPTH under stall, third burst ignored, drain in order
    outStall = 1'b1;
    burst4(5'd1, 32'h0000_00A0); tick();
    check("t3_count4", 32'(count), 32'd4);
    check("t3_ready4", 32'(inReady), 32'd1);
    burst4(5'd5, 32'h0000_00A4); tick();
    check("t3_count8", 32'(count), 32'd8);
    check("t3_ready8", 32'(inReady), 32'd0);
    burst4(5'd9, 32'h0000_00A8); tick();
    check("t3_ignored", 32'(count), 32'd8);
    check_head("t3_stalled", 5'd1, 32'h0000_00A0);
    idle_lanes(); outStall = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check_head($sformatf("t3_pop%0d", i), 5'(i + 1), 32'h0000_00A0 + 32'(i));
      check($sformatf("t3_rdy%0d", i), 32'(inReady), (i >= 4) ? 32'd1 : 32'd0);
      tick();
    end
    check_empty("t3_done");

    // steady single-lane stream, pointers wrap twice
    for (int k = 0; k < 20; k++) begin
      inValid0 = 1; inAddr0 = 5'(k % 31 + 1); inData0 = 32'h0000_1000 + 32'(k);
      tick();
      check($sformatf("t4_count%0d", k), 32'(count), 32'd1);
      check_head($sformatf("t4_h%0d", k), 5'(k % 31 + 1), 32'h0000_1000 + 32'(k));
    end
    idle_lanes(); tick();
    check_empty("t4_done");

    // flush beats a same-cycle burst and pop
    outStall = 1'b1;
    burst4(5'd10, 32'h0000_0B00); tick();
    idle_lanes();
    inValid0 = 1; inAddr0 = 5'd20; inData0 = 32'h0000_0B04; tick();
    check("t5_count5", 32'(count), 32'd5);
    outStall = 1'b0;
    burst4(5'd24, 32'h0000_0C00); flush = 1'b1;
    check_head("t5_head_at_flush", 5'd10, 32'h0000_0B00);
    tick();
    flush = 1'b0; idle_lanes();
    check_empty("t5_flushed");
    tick();
    check_empty("t5_after");

    // asynchronous reset mid-operation
    outStall = 1'b1;
    burst4(5'd3, 32'h0000_0D00); tick(); idle_lanes();
    check("t6_count4", 32'(count), 32'd4);
    #2 rstN = 1'b0;
    #1 check_empty("t6_async");
    check("t6_ready", 32'(inReady), 32'd1);
    #3 rstN = 1'b1;
    outStall = 1'b0;
    tick();
    check_empty("t6_resume");

    // writes to register 0
    inValid0 = 1; inAddr0 = 5'd0; inData0 = 32'h0000_2222;
    tick(); idle_lanes();
`ifdef WB_QUEUE_ZERO_DROP_EN
    check_empty("t7_dropped");
`else
    check("t7_count1", 32'(count), 32'd1);
    check_head("t7_zero", 5'd0, 32'h0000_2222);
    tick();
    check_empty("t7_done");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
